noise_injector: RTL

- Downstream consumer of the noise matrix that the noise filler writes into BRAM.
- Streams a feature map channel by channel. Each channel has size×size pixels.
- For every pixel it adds the BRAM noise sample multiplied by that channel's learned scale, in the style of StyleGAN per-pixel noise injection. The same noise map is broadcast to all channels.
- Reads noise BRAM and scale BRAM, each with 1-cycle synchronous read. Output is a saturated Q3.13 valid/ready stream to the next conv/activation stage.

---
 rtl/noise_injector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/noise_injector.sv
// StyleGAN-style per-pixel noise injection. Each feature pixel gets the shared
// BRAM noise sample times its channel's scale added, saturated to Q3.13.
module noise_injector #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 13,
    parameter int ADDR_WIDTH = 14,
    parameter int CH_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            size,
    input  logic [CH_WIDTH-1:0]   num_ch_m1,
    output logic [ADDR_WIDTH-1:0] noise_addr,
    input  logic [DATA_WIDTH-1:0] noise_rdata,
    output logic [CH_WIDTH-1:0]   scale_addr,
    input  logic [DATA_WIDTH-1:0] scale_rdata,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_SCALE = 3'd1,
        PRIME      = 3'd2,
        RUN        = 3'd3,
        DRAIN      = 3'd4,
        DONE       = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pix_q, pix_d;
    logic [ADDR_WIDTH-1:0]   limit_q, limit_d;
    logic [ADDR_WIDTH-1:0]   limit_dec;
    logic [CH_WIDTH-1:0]     ch_q, ch_d;
    logic [CH_WIDTH-1:0]     nch_q, nch_d;
    logic [CH_WIDTH-1:0]     scale_addr_q, scale_addr_d;
    logic [DATA_WIDTH-1:0]   scale_reg_q, scale_reg_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;
    logic                    fire;

    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    prod_sh;
    logic signed [SW-1:0]    sum;
    logic [DATA_WIDTH-1:0]   sat;

    // Pixel limit is size*size - 1 for the power-of-two edge selected by size.
    always_comb begin
        case (size)
            3'd0:    limit_dec = ADDR_WIDTH'(15);
            3'd1:    limit_dec = ADDR_WIDTH'(63);
            3'd2:    limit_dec = ADDR_WIDTH'(255);
            3'd3:    limit_dec = ADDR_WIDTH'(1023);
            3'd4:    limit_dec = ADDR_WIDTH'(4095);
            default: limit_dec = ADDR_WIDTH'(16383);
        endcase
    end

    assign prod    = $signed(noise_rdata) * $signed(scale_reg_q);
    assign prod_sh = SW'(prod >>> FRAC_BITS);
    assign sum     = SW'($signed(s_data)) + prod_sh;

    always_comb begin
        if (sum[SW-1:DATA_WIDTH-1] == '0 || sum[SW-1:DATA_WIDTH-1] == '1) begin
            sat = sum[DATA_WIDTH-1:0];
        end else if (sum[SW-1]) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // valid and ready are both high; valid never waits on ready, and a held
    // beat keeps its data and last flag unchanged until it transfers.
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        limit_d      = limit_q;
        ch_d         = ch_q;
        nch_d        = nch_q;
        scale_addr_d = scale_addr_q;
        scale_reg_d  = scale_reg_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        done_d       = done_q;
        s_ready      = 1'b0;
        fire         = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    limit_d      = limit_dec;
                    nch_d        = num_ch_m1;
                    ch_d         = '0;
                    pix_d        = '0;
                    scale_addr_d = '0;
                    state_d      = LOAD_SCALE;
                end
            end
            LOAD_SCALE: state_d = PRIME;
            PRIME: begin
                scale_reg_d = scale_rdata;
                state_d     = RUN;
            end
            RUN: begin
                s_ready = !m_valid_q || m_ready;
                fire    = s_valid && s_ready;
                if (fire) begin
                    m_data_d  = sat;
                    m_valid_d = 1'b1;
                    m_last_d  = (pix_q == limit_q);
                    if (pix_q == limit_q) begin
                        pix_d = '0;
                        if (ch_q < nch_q) begin
                            ch_d         = ch_q + 1'b1;
                            scale_addr_d = ch_q + 1'b1;
                            state_d      = LOAD_SCALE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address runs one pixel ahead on a transfer so the synchronous read lands
    // with the pixel it belongs to; stalls simply hold it.
    assign noise_addr = pix_d;
    assign scale_addr = scale_addr_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            limit_q      <= '0;
            ch_q         <= '0;
            nch_q        <= '0;
            scale_addr_q <= '0;
            scale_reg_q  <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            limit_q      <= limit_d;
            ch_q         <= ch_d;
            nch_q        <= nch_d;
            scale_addr_q <= scale_addr_d;
            scale_reg_q  <= scale_reg_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
        end
    end

endmodule
